// File: rtl/tpu_pkg.sv
// Shared sizes and state encoding for the accumulator drain / quantiser path.
package tpu_pkg;

   localparam int DATA_SIZE = 20;
   localparam int DATA_NUM  = 16;
   localparam int OUT_SIZE  = 8;
   localparam int ACC_AW    = 4;
   localparam int UB_AW     = 8;

   localparam int SHIFT_MAX = DATA_SIZE - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } drain_state_e;

   // Shift amounts beyond the lane width behave like the widest useful shift.
   function automatic logic [4:0] clamp_shift(input logic [4:0] s);
      return (s > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : s;
   endfunction

endpackage

// File: rtl/acc_quant_lane.sv
// One lane of the drain quantiser: optional ReLU, round-half-up arithmetic
// right shift, then saturation to the signed output width.
module acc_quant_lane
   import tpu_pkg::*;
(
   input  logic [DATA_SIZE-1:0] lane_in,
   input  logic [4:0]           shift,
   input  logic                 relu,
   output logic [OUT_SIZE-1:0]  lane_out
);

   localparam logic signed [DATA_SIZE:0] ONE     = (DATA_SIZE+1)'(1);
   localparam logic signed [DATA_SIZE:0] SAT_MAX = (DATA_SIZE+1)'(2**(OUT_SIZE-1) - 1);
   localparam logic signed [DATA_SIZE:0] SAT_MIN = (DATA_SIZE+1)'(-(2**(OUT_SIZE-1)));

   logic signed [DATA_SIZE:0] r_ext;
   logic signed [DATA_SIZE:0] rnd;
   logic signed [DATA_SIZE:0] sum;
   logic signed [DATA_SIZE:0] shifted;

   // One extra bit of headroom keeps the rounding add from wrapping.
   always_comb begin
      r_ext = (relu && lane_in[DATA_SIZE-1]) ? '0 : {lane_in[DATA_SIZE-1], lane_in};
      rnd   = '0;
      if (shift != 5'd0) begin
         rnd = ONE << (shift - 5'd1);
      end
      sum     = r_ext + rnd;
      shifted = sum >>> shift;
      if (shifted > SAT_MAX) begin
         lane_out = SAT_MAX[OUT_SIZE-1:0];
      end else if (shifted < SAT_MIN) begin
         lane_out = SAT_MIN[OUT_SIZE-1:0];
      end else begin
         lane_out = shifted[OUT_SIZE-1:0];
      end
   end

endmodule

// File: rtl/acc_drain_quant.sv
// Drains a run of accumulator rows, quantises each lane to 8 bits and streams
// packed rows with destination addresses through a 2-entry fall-through FIFO.
//
//   state | meaning
//   IDLE  | waiting for start; cfg_* captured on an accepted start
//   RUN   | issuing reads and handing rows downstream
//   FIN   | single-cycle done pulse, last busy cycle
module acc_drain_quant
   import tpu_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ACC_AW-1:0]             cfg_acc_base,
   input  logic [ACC_AW:0]               cfg_count,
   input  logic [UB_AW-1:0]              cfg_ub_base,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_relu,
   output logic                          busy,
   output logic                          done,
   output logic                          acc_enb,
   output logic [ACC_AW-1:0]             acc_addrb,
   input  logic [DATA_NUM*DATA_SIZE-1:0] acc_doutb,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [UB_AW-1:0]              out_addr,
   output logic [DATA_NUM*OUT_SIZE-1:0]  out_data
);

   localparam int CNT_W = ACC_AW + 1;
   localparam int ROW_W = DATA_NUM * OUT_SIZE;

   drain_state_e      state_q, state_d;
   logic [CNT_W-1:0]  issue_left_q, issue_left_d;
   logic [CNT_W-1:0]  accept_left_q, accept_left_d;
   logic [ACC_AW-1:0] rd_addr_q, rd_addr_d;
   logic [UB_AW-1:0]  push_addr_q, push_addr_d;
   logic [4:0]        shift_q, shift_d;
   logic              relu_q, relu_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        occ_q, occ_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [UB_AW-1:0]  fifo_addr_q [2];
   logic [UB_AW-1:0]  fifo_addr_d [2];
   logic [ROW_W-1:0]  fifo_data_q [2];
   logic [ROW_W-1:0]  fifo_data_d [2];

   logic [ROW_W-1:0]  quant_row;
   logic              push;
   logic              pop;
   logic              issue;
   logic [2:0]        pending;

   for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
      acc_quant_lane u_lane (
         .lane_in  (acc_doutb[i*DATA_SIZE +: DATA_SIZE]),
         .shift    (shift_q),
         .relu     (relu_q),
         .lane_out (quant_row[i*OUT_SIZE +: OUT_SIZE])
      );
   end

   assign out_valid = (occ_q != 2'd0);
   assign out_addr  = fifo_addr_q[rd_ptr_q];
   assign out_data  = fifo_data_q[rd_ptr_q];
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIN);
   assign acc_enb   = issue;
   assign acc_addrb = rd_addr_q;

   // A row may be issued if, after this cycle's pop, the FIFO plus the row
   // already in flight still leaves a free slot for it when it lands.
   always_comb begin
      push    = inflight_q;
      pop     = out_valid && out_ready;
      pending = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
      issue   = (state_q == RUN) && (issue_left_q != '0) && (pending < 3'd2);
   end

   always_comb begin
      state_d       = state_q;
      issue_left_d  = issue_left_q;
      accept_left_d = accept_left_q;
      rd_addr_d     = rd_addr_q;
      push_addr_d   = push_addr_q;
      shift_d       = shift_q;
      relu_d        = relu_q;
      inflight_d    = issue;
      occ_d         = occ_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fifo_addr_d   = fifo_addr_q;
      fifo_data_d   = fifo_data_q;

      if (issue) begin
         rd_addr_d    = rd_addr_q + ACC_AW'(1);
         issue_left_d = issue_left_q - CNT_W'(1);
      end

      if (push) begin
         fifo_addr_d[wr_ptr_q] = push_addr_q;
         fifo_data_d[wr_ptr_q] = quant_row;
         wr_ptr_d              = ~wr_ptr_q;
         push_addr_d           = push_addr_q + UB_AW'(1);
      end

      if (pop) begin
         rd_ptr_d      = ~rd_ptr_q;
         accept_left_d = accept_left_q - CNT_W'(1);
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               rd_addr_d     = cfg_acc_base;
               push_addr_d   = cfg_ub_base;
               issue_left_d  = cfg_count;
               accept_left_d = cfg_count;
               shift_d       = clamp_shift(cfg_shift);
               relu_d        = cfg_relu;
               state_d       = (cfg_count == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            if (pop && (accept_left_q == CNT_W'(1))) begin
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         issue_left_q  <= '0;
         accept_left_q <= '0;
         rd_addr_q     <= '0;
         push_addr_q   <= '0;
         shift_q       <= '0;
         relu_q        <= 1'b0;
         inflight_q    <= 1'b0;
         occ_q         <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         fifo_addr_q   <= '{default: '0};
         fifo_data_q   <= '{default: '0};
      end else begin
         state_q       <= state_d;
         issue_left_q  <= issue_left_d;
         accept_left_q <= accept_left_d;
         rd_addr_q     <= rd_addr_d;
         push_addr_q   <= push_addr_d;
         shift_q       <= shift_d;
         relu_q        <= relu_d;
         inflight_q    <= inflight_d;
         occ_q         <= occ_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_addr_q   <= fifo_addr_d;
         fifo_data_q   <= fifo_data_d;
      end
   end

endmodule
